// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the register-transfer datapath.
// Sequences fetch (T0-T2), then executes ALU, mul/div, ld, nop and halt in T3-T7.
// The control outputs are a Moore decode of the state register. The register
// indices are taken from IR, which is stable from T3 onward.
// Optional build macro SEQ_MEM_TIMEOUT_EN: a 4-bit wait counter that halts with
// a sticky fault after 16 consecutive cycles without mem_ready. Without the
// macro, memory waits are unbounded and fault is tied low.
module control_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRread,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Cout,
  output logic        HIin,
  output logic        Loin,
  output logic        ZLowSelect,
  output logic        ZLOout,
  output logic        ZHighSelect,
  output logic        ZHIout,
  output logic [4:0]  ALU_opcode,
  output logic        mem_read,
  output logic        run,
  output logic        fault,
  output logic [3:0]  step
);

  typedef enum logic [3:0] {
    T0   = 4'd0,
    T1   = 4'd1,
    T2   = 4'd2,
    T3   = 4'd3,
    T4   = 4'd4,
    T5   = 4'd5,
    T6   = 4'd6,
    T7   = 4'd7,
    HALT = 4'd15
  } state_t;

  state_t     state;
  logic [4:0] opc;
  logic [3:0] ra, rb, rc;
  logic       is_alu, is_muldiv, is_ld, is_halt;
  logic       timeout;
  logic       unused_ir;

  assign opc       = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  assign is_alu    = (opc >= 5'd3) && (opc <= 5'd11);
  assign is_muldiv = (opc == 5'd15) || (opc == 5'd16);
  assign is_ld     = (opc == 5'd0);
  assign is_halt   = (opc == 5'd27);

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    onehot16 = 16'h0001 << idx;
  endfunction

`ifdef SEQ_MEM_TIMEOUT_EN
  logic [3:0] wait_cnt;
  logic       fault_q;
  logic       mem_wait;

  assign mem_wait = (state == T1) || ((state == T6) && is_ld);
  assign timeout  = mem_wait && !mem_ready && (wait_cnt == 4'hF);
  assign fault    = fault_q;

  // Count consecutive memory-wait cycles; fault latches once the budget is spent
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wait_cnt <= 4'd0;
      fault_q  <= 1'b0;
    end else begin
      if ((state == T0) || ((state == T5) && is_ld))
        wait_cnt <= 4'd0;
      else if (mem_wait && !mem_ready)
        wait_cnt <= wait_cnt + 4'd1;
      if (timeout)
        fault_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif

  // State sequencing: fetch, decode by opcode class, memory-ready stalls, halt
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= T0;
    end else begin
      case (state)
        T0: state <= T1;
        T1: begin
          if (mem_ready)    state <= T2;
          else if (timeout) state <= HALT;
        end
        T2: state <= T3;
        T3: begin
          if (is_halt)                        state <= HALT;
          else if (is_alu || is_muldiv || is_ld) state <= T4;
          else                                state <= T0;
        end
        T4: state <= T5;
        T5: state <= is_alu ? T0 : T6;
        T6: begin
          if (!is_ld)         state <= T0;
          else if (mem_ready) state <= T7;
          else if (timeout)   state <= HALT;
        end
        T7:      state <= T0;
        HALT:    state <= HALT;
        default: state <= T0;
      endcase
    end
  end

  assign step = state;
  assign run  = (state != HALT);

  // Moore decode of the datapath enables from the current state and opcode class
  always_comb begin
    Rin = 16'h0000; Rout = 16'h0000;
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRread = 1'b0; MDRout = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; Cout = 1'b0; HIin = 1'b0; Loin = 1'b0;
    ZLowSelect = 1'b0; ZLOout = 1'b0; ZHighSelect = 1'b0; ZHIout = 1'b0;
    ALU_opcode = 5'd0; mem_read = 1'b0;
    case (state)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      T1: begin mem_read = 1'b1; MDRread = 1'b1; MDRin = 1'b1; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: begin
        if (is_alu || is_ld) begin Rout = onehot16(rb); Yin = 1'b1; end
        else if (is_muldiv)  begin Rout = onehot16(ra); Yin = 1'b1; end
      end
      T4: begin
        Zin = 1'b1;
        if (is_ld) begin Cout = 1'b1; ALU_opcode = 5'd3; end
        else begin
          Rout       = is_muldiv ? onehot16(rb) : onehot16(rc);
          ALU_opcode = opc;
        end
      end
      T5: begin
        ZLowSelect = 1'b1; ZLOout = 1'b1;
        if (is_alu)         Rin   = onehot16(ra);
        else if (is_muldiv) Loin  = 1'b1;
        else                MARin = 1'b1;
      end
      T6: begin
        if (is_ld) begin mem_read = 1'b1; MDRread = 1'b1; MDRin = 1'b1; end
        else begin ZHighSelect = 1'b1; ZHIout = 1'b1; HIin = 1'b1; end
      end
      T7: begin MDRout = 1'b1; Rin = onehot16(ra); end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed bench with a per-instruction trace model.
// The model expands each instruction into the list of cycles it must take and
// the enables each cycle must show; one compare process checks every cycle.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] IR;
  logic        mem_ready;
  logic [15:0] Rin, Rout;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRread, MDRout, IRin;
  logic        Yin, Zin, Cout, HIin, Loin;
  logic        ZLowSelect, ZLOout, ZHighSelect, ZHIout;
  logic [4:0]  ALU_opcode;
  logic        mem_read, run, fault;
  logic [3:0]  step;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .clr(clr), .IR(IR), .mem_ready(mem_ready),
    .Rin(Rin), .Rout(Rout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRread(MDRread), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .Cout(Cout), .HIin(HIin), .Loin(Loin),
    .ZLowSelect(ZLowSelect), .ZLOout(ZLOout), .ZHighSelect(ZHighSelect),
    .ZHIout(ZHIout), .ALU_opcode(ALU_opcode), .mem_read(mem_read),
    .run(run), .fault(fault), .step(step)
  );

  // enable bit positions in the packed enable vector
  localparam logic [17:0] B_PCOUT = 18'h00001, B_PCIN  = 18'h00002, B_INCPC = 18'h00004,
                          B_MARIN = 18'h00008, B_MDRIN = 18'h00010, B_MDRRD = 18'h00020,
                          B_MDROUT= 18'h00040, B_IRIN  = 18'h00080, B_YIN   = 18'h00100,
                          B_ZIN   = 18'h00200, B_COUT  = 18'h00400, B_HIIN  = 18'h00800,
                          B_LOIN  = 18'h01000, B_ZLS   = 18'h02000, B_ZLO   = 18'h04000,
                          B_ZHS   = 18'h08000, B_ZHI   = 18'h10000, B_MEMRD = 18'h20000;

  logic [17:0] en_act;
  assign en_act = {mem_read, ZHIout, ZHighSelect, ZLOout, ZLowSelect, Loin, HIin, Cout,
                   Zin, Yin, IRin, MDRout, MDRread, MDRin, MARin, IncPC, PCin, PCout};

  typedef struct packed {
    logic [31:0] ir;
    logic        mr;
    logic [3:0]  step;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [17:0] en;
    logic [4:0]  alu;
    logic        run;
    logic        fault;
  } rec_t;

  rec_t q[$];
  rec_t exp_cur;
  logic exp_valid = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  function automatic rec_t mk(input logic [31:0] ir, input logic [3:0] st, input logic [17:0] en,
                              input logic [15:0] rin, input logic [15:0] rout,
                              input logic [4:0] alu, input logic mr);
    rec_t r;
    r.ir = ir; r.mr = mr; r.step = st; r.rin = rin; r.rout = rout;
    r.en = en; r.alu = alu; r.run = 1'b1; r.fault = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'd0};
  endfunction

  // Expand one instruction into its expected cycles; w1/w6 are stall cycles in T1/T6
  task automatic add_instr(input logic [31:0] ir, input int w1, input int w6);
    logic [4:0]  op;
    logic [15:0] ha, hb, hc;
    rec_t        r;
    op = ir[31:27];
    ha = 16'h0001 << ir[26:23];
    hb = 16'h0001 << ir[22:19];
    hc = 16'h0001 << ir[18:15];
    q.push_back(mk(ir, 4'd0, B_PCOUT | B_MARIN | B_INCPC, 16'h0, 16'h0, 5'd0, 1'b0));
    for (int i = 0; i < w1; i++)
      q.push_back(mk(ir, 4'd1, B_MEMRD | B_MDRRD | B_MDRIN, 16'h0, 16'h0, 5'd0, 1'b0));
    q.push_back(mk(ir, 4'd1, B_MEMRD | B_MDRRD | B_MDRIN, 16'h0, 16'h0, 5'd0, 1'b1));
    q.push_back(mk(ir, 4'd2, B_MDROUT | B_IRIN, 16'h0, 16'h0, 5'd0, 1'b0));
    if (op >= 5'd3 && op <= 5'd11) begin
      q.push_back(mk(ir, 4'd3, B_YIN, 16'h0, hb, 5'd0, 1'b0));
      q.push_back(mk(ir, 4'd4, B_ZIN, 16'h0, hc, op, 1'b0));
      q.push_back(mk(ir, 4'd5, B_ZLS | B_ZLO, ha, 16'h0, 5'd0, 1'b0));
    end else if (op == 5'd15 || op == 5'd16) begin
      q.push_back(mk(ir, 4'd3, B_YIN, 16'h0, ha, 5'd0, 1'b0));
      q.push_back(mk(ir, 4'd4, B_ZIN, 16'h0, hb, op, 1'b0));
      q.push_back(mk(ir, 4'd5, B_ZLS | B_ZLO | B_LOIN, 16'h0, 16'h0, 5'd0, 1'b0));
      q.push_back(mk(ir, 4'd6, B_ZHS | B_ZHI | B_HIIN, 16'h0, 16'h0, 5'd0, 1'b0));
    end else if (op == 5'd0) begin
      q.push_back(mk(ir, 4'd3, B_YIN, 16'h0, hb, 5'd0, 1'b0));
      q.push_back(mk(ir, 4'd4, B_COUT | B_ZIN, 16'h0, 16'h0, 5'd3, 1'b0));
      q.push_back(mk(ir, 4'd5, B_ZLS | B_ZLO | B_MARIN, 16'h0, 16'h0, 5'd0, 1'b0));
      for (int i = 0; i < w6; i++)
        q.push_back(mk(ir, 4'd6, B_MEMRD | B_MDRRD | B_MDRIN, 16'h0, 16'h0, 5'd0, 1'b0));
      q.push_back(mk(ir, 4'd6, B_MEMRD | B_MDRRD | B_MDRIN, 16'h0, 16'h0, 5'd0, 1'b1));
      q.push_back(mk(ir, 4'd7, B_MDROUT, ha, 16'h0, 5'd0, 1'b0));
    end else begin
      q.push_back(mk(ir, 4'd3, 18'h0, 16'h0, 16'h0, 5'd0, 1'b0));
      if (op == 5'd27) begin
        for (int i = 0; i < 22; i++) begin
          r = mk(ir, 4'd15, 18'h0, 16'h0, 16'h0, 5'd0, 1'(i % 2));
          r.run = 1'b0;
          q.push_back(r);
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic compare_now();
    total++;
    if ({step, Rin, Rout, en_act, ALU_opcode, run, fault} !==
        {exp_cur.step, exp_cur.rin, exp_cur.rout, exp_cur.en, exp_cur.alu, exp_cur.run, exp_cur.fault}) begin
      bad++;
      $display("FAIL trace cyc%0d ir=%h step=%0d/%0d Rin=%h/%h Rout=%h/%h en=%h/%h alu=%0d/%0d run=%b/%b fault=%b/%b (actual/required)",
               cyc, exp_cur.ir, step, exp_cur.step, Rin, exp_cur.rin, Rout, exp_cur.rout,
               en_act, exp_cur.en, ALU_opcode, exp_cur.alu, run, exp_cur.run, fault, exp_cur.fault);
    end
  endtask

  task automatic play_n(input int n);
    for (int i = 0; i < n && q.size() > 0; i++) begin
      exp_cur   = q.pop_front();
      IR        = exp_cur.ir;
      mem_ready = exp_cur.mr;
      exp_valid = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    exp_valid = 1'b0;
  endtask

  task automatic play();
    play_n(q.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t r;
    logic [31:0] ir;
    clr = 1'b1; IR = 32'h0; mem_ready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (exp_valid) compare_now();
      end
    join_none

    // reset state
    @(posedge clk); #1;
    check("rst_step", 32'(step), 32'd0);
    check("rst_fetch_en", 32'(en_act), 32'(B_PCOUT | B_MARIN | B_INCPC));
    check("rst_rin_rout", {Rin, Rout}, 32'h0);
    check("rst_run", 32'(run), 32'd1);
    check("rst_fault", 32'(fault), 32'd0);
    clr = 1'b0;

    // add R5,R2,R4 with pinned model expectations
    add_instr(mk_ir(5'd3, 4'd5, 4'd2, 4'd4), 0, 0);
    check("model_add_len", q.size(), 32'd6);
    check("model_add_t3_rout", 32'(q[3].rout), 32'h0004);
    check("model_add_t4_rout", 32'(q[4].rout), 32'h0010);
    check("model_add_t4_alu", 32'(q[4].alu), 32'd3);
    check("model_add_t5_rin", 32'(q[5].rin), 32'h0020);
    play();
    check("add_back_t0", 32'(step), 32'd0);

    // mul R3,R1
    add_instr(32'h79880000, 0, 0);
    check("model_mul_len", q.size(), 32'd7);
    check("model_mul_t5_loin", 32'(q[5].en & (B_LOIN | B_ZLS)), 32'(B_LOIN | B_ZLS));
    check("model_mul_t6_hiin", 32'(q[6].en & (B_HIIN | B_ZHS)), 32'(B_HIIN | B_ZHS));
    play();
    check("mul_back_t0", 32'(step), 32'd0);

    // ld R1,5(R2) with three T6 stalls
    add_instr(32'h00900005, 0, 3);
    check("model_ld_len", q.size(), 32'd11);
    check("model_ld_t7_rin", 32'(q[10].rin), 32'h0002);
    check("model_ld_t6_cnt", 32'((q[6].step == 4'd6) && (q[9].step == 4'd6)), 32'd1);
    play();

    // all ALU ops, assorted registers and fetch stalls
    for (int k = 0; k < 9; k++) begin
      ir = mk_ir(5'(3 + k), 4'(k * 5 + 1), 4'(15 - k), 4'(k * 3));
      add_instr(ir, k % 3, 0);
    end
    add_instr(mk_ir(5'd16, 4'd8, 4'd14, 4'd0), 1, 0);
    add_instr(mk_ir(5'd0, 4'd15, 4'd9, 4'd0) | 32'h7, 2, 0);
    add_instr(mk_ir(5'd26, 4'd1, 4'd2, 4'd3), 0, 0);
    add_instr(mk_ir(5'd1, 4'd4, 4'd5, 4'd6), 0, 0);
    add_instr(mk_ir(5'd12, 4'd0, 4'd0, 4'd0), 1, 0);
    add_instr(mk_ir(5'd31, 4'd9, 4'd9, 4'd9), 0, 0);
    add_instr(mk_ir(5'd3, 4'd0, 4'd15, 4'd15), 0, 0);
    play();

    // clr in the middle of T4 aborts at once; next instruction fetches cleanly
    add_instr(mk_ir(5'd3, 4'd5, 4'd2, 4'd4), 0, 0);
    play_n(4);
    check("abort_in_t4", 32'(step), 32'd4);
    #2 clr = 1'b1;
    #1;
    check("abort_step", 32'(step), 32'd0);
    check("abort_en", 32'(en_act), 32'(B_PCOUT | B_MARIN | B_INCPC));
    check("abort_rin_rout", {Rin, Rout}, 32'h0);
    check("abort_run_fault", 32'({run, fault}), 32'h2);
    q.delete();
    @(posedge clk); #1;
    clr = 1'b0;
    add_instr(mk_ir(5'd26, 4'd0, 4'd0, 4'd0), 0, 0);
    play();

`ifdef SEQ_MEM_TIMEOUT_EN
    // 16 consecutive wait cycles in T1 end in HALT with a sticky fault
    ir = mk_ir(5'd3, 4'd1, 4'd2, 4'd3);
    q.push_back(mk(ir, 4'd0, B_PCOUT | B_MARIN | B_INCPC, 16'h0, 16'h0, 5'd0, 1'b0));
    for (int i = 0; i < 16; i++)
      q.push_back(mk(ir, 4'd1, B_MEMRD | B_MDRRD | B_MDRIN, 16'h0, 16'h0, 5'd0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      r = mk(ir, 4'd15, 18'h0, 16'h0, 16'h0, 5'd0, 1'(i % 2));
      r.run = 1'b0; r.fault = 1'b1;
      q.push_back(r);
    end
    play();
    check("timeout_fault", 32'(fault), 32'd1);
    clr = 1'b1;
    #1;
    check("timeout_clr_fault", 32'(fault), 32'd0);
    check("timeout_clr_step", 32'(step), 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
`else
    // without the timeout, a long T1 stall just waits and then completes
    add_instr(mk_ir(5'd26, 4'd0, 4'd0, 4'd0), 30, 0);
    play();
    check("long_wait_fault", 32'(fault), 32'd0);
`endif

    // halt, then only clr leaves HALT
    add_instr(32'hD8000000, 0, 0);
    play();
    check("halt_step", 32'(step), 32'd15);
    clr = 1'b1;
    #1;
    check("halt_clr_step", 32'(step), 32'd0);
    check("halt_clr_run", 32'(run), 32'd1);
    @(posedge clk); #1;
    clr = 1'b0;
    add_instr(mk_ir(5'd4, 4'd7, 4'd3, 4'd11), 0, 0);
    play();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
